// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, addresses instruction memory, and registers the
// returned word into IF/ID with redirect, stall and flush handling.
module instruction_fetch #(
  parameter int          ADDR_WIDTH = 7,
  parameter int unsigned RESET_PC   = 0,
  parameter int          CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  branch_taken,
  input  logic signed [15:0]    branch_offset,
  input  logic                  jump,
  input  logic [25:0]           jump_target,
  input  logic [31:0]           instruction,
  output logic [ADDR_WIDTH-1:0] im_readAddr,
  output logic [31:0]           ifid_instr,
  output logic [ADDR_WIDTH-1:0] ifid_pc_plus1,
  output logic                  ifid_valid,
  output logic [CNT_WIDTH-1:0]  fetch_count
);

  localparam logic [ADDR_WIDTH-1:0] RESET_PC_W = RESET_PC[ADDR_WIDTH-1:0];

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [ADDR_WIDTH-1:0] r_pc_p0;
  logic [31:0]           r_ifid_instr_p1;
  logic [ADDR_WIDTH-1:0] r_ifid_pc1_p1;
  logic                  r_ifid_vld_p1;
  logic [CNT_WIDTH-1:0]  r_fetch_count;

  logic                  w_redirect;
  logic                  w_bubble;
  logic                  w_load;
  logic [ADDR_WIDTH-1:0] w_pc_plus1;
  logic [ADDR_WIDTH-1:0] w_branch_tgt;
  logic [ADDR_WIDTH-1:0] w_pc_next;
  logic                  w_unused;

  // Only the low ADDR_WIDTH bits of the target and offset matter after wrap.
  assign w_unused     = ^{jump_target[25:ADDR_WIDTH], branch_offset[15:ADDR_WIDTH]};

  assign w_redirect   = jump | branch_taken;
  assign w_bubble     = flush | w_redirect;
  assign w_load       = !w_bubble && !stall;
  assign w_pc_plus1   = r_pc_p0 + 1'b1;
  assign w_branch_tgt = r_ifid_pc1_p1 + branch_offset[ADDR_WIDTH-1:0];

  always_comb begin
    w_pc_next = w_pc_plus1;
    if (jump)              w_pc_next = jump_target[ADDR_WIDTH-1:0];
    else if (branch_taken) w_pc_next = w_branch_tgt;
    else if (stall)        w_pc_next = r_pc_p0;
  end

  // Stage p0 -> p1: PC advance and IF/ID capture
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc_p0         <= RESET_PC_W;
      r_ifid_instr_p1 <= '0;
      r_ifid_pc1_p1   <= '0;
      r_ifid_vld_p1   <= 1'b0;
      r_fetch_count   <= '0;
    end else begin
      r_pc_p0 <= w_pc_next;
      if (w_bubble) begin
        r_ifid_instr_p1 <= '0;
        r_ifid_vld_p1   <= 1'b0;
      end else if (w_load) begin
        r_ifid_instr_p1 <= instruction;
        r_ifid_pc1_p1   <= w_pc_plus1;
        r_ifid_vld_p1   <= 1'b1;
      end
      if (w_load) r_fetch_count <= sat_inc(r_fetch_count);
    end
  end

  assign im_readAddr   = r_pc_p0;
  assign ifid_instr    = r_ifid_instr_p1;
  assign ifid_pc_plus1 = r_ifid_pc1_p1;
  assign ifid_valid    = r_ifid_vld_p1;
  assign fetch_count   = r_fetch_count;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios followed by randomized
// traffic, all outputs compared every cycle against an integer-level model.
module tb_instruction_fetch;

  localparam int AW    = 7;
  localparam int CW    = 5;
  localparam int DEPTH = 1 << AW;
  localparam int CMAX  = (1 << CW) - 1;

  logic                 clk;
  logic                 reset, stall, flush, branch_taken, jump;
  logic signed [15:0]   branch_offset;
  logic [25:0]          jump_target;
  logic [31:0]          instruction;
  logic [AW-1:0]        im_readAddr;
  logic [31:0]          ifid_instr;
  logic [AW-1:0]        ifid_pc_plus1;
  logic                 ifid_valid;
  logic [CW-1:0]        fetch_count;

  logic [31:0] mem [DEPTH];
  int errors = 0;
  int checks = 0;

  // Reference state: plain integers, modulo arithmetic on the word space
  int m_pc, m_pc1, m_valid, m_cnt;
  logic [31:0] m_instr;

  instruction_fetch #(.ADDR_WIDTH(AW), .RESET_PC(0), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .branch_taken(branch_taken), .branch_offset(branch_offset),
    .jump(jump), .jump_target(jump_target), .instruction(instruction),
    .im_readAddr(im_readAddr), .ifid_instr(ifid_instr),
    .ifid_pc_plus1(ifid_pc_plus1), .ifid_valid(ifid_valid),
    .fetch_count(fetch_count)
  );

  assign instruction = mem[im_readAddr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit s, input bit f, input bit b,
                            input int off, input bit j, input int jt);
    int npc;
    if (r) begin
      m_pc = 0; m_pc1 = 0; m_valid = 0; m_cnt = 0; m_instr = '0;
      return;
    end
    if (j)      npc = jt % DEPTH;
    else if (b) npc = (((m_pc1 + off) % DEPTH) + DEPTH) % DEPTH;
    else if (s) npc = m_pc;
    else        npc = (m_pc + 1) % DEPTH;
    if (f || j || b) begin
      m_instr = '0; m_valid = 0;
    end else if (!s) begin
      m_instr = mem[m_pc];
      m_pc1   = (m_pc + 1) % DEPTH;
      m_valid = 1;
      m_cnt   = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
    end
    m_pc = npc;
  endtask

  task automatic cyc(input bit r, input bit s, input bit f, input bit b,
                     input logic [15:0] off, input bit j, input logic [25:0] jt);
    @(negedge clk);
    reset = r; stall = s; flush = f; branch_taken = b;
    branch_offset = off; jump = j; jump_target = jt;
    @(posedge clk);
    model_step(r, s, f, b, int'($signed(off)), j, int'(jt));
    #1;
    chk("pc",    32'(im_readAddr),   32'(m_pc));
    chk("instr", ifid_instr,         m_instr);
    chk("pc1",   32'(ifid_pc_plus1), 32'(m_pc1));
    chk("valid", 32'(ifid_valid),    32'(m_valid));
    chk("count", 32'(fetch_count),   32'(m_cnt));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 16'h0, 0, 26'h0);
  endtask

  initial begin
    logic [CW-1:0] saved_cnt;
    for (int i = 0; i < DEPTH; i++) mem[i] = {$urandom_range(16'hFFFF, 1), 16'(i)};
    reset = 1; stall = 0; flush = 0; branch_taken = 0; jump = 0;
    branch_offset = '0; jump_target = '0;
    m_pc = 0; m_pc1 = 0; m_valid = 0; m_cnt = 0; m_instr = '0;

    // Reset held two cycles, then sequential fetch
    cyc(1, 0, 0, 0, 16'h0, 0, 26'h0);
    cyc(1, 0, 0, 0, 16'h0, 0, 26'h0);
    chk("rst_pc", 32'(im_readAddr), 32'd0);
    chk("rst_valid", 32'(ifid_valid), 32'd0);
    chk("rst_count", 32'(fetch_count), 32'd0);
    run(1);
    chk("seq_pc1", 32'(im_readAddr), 32'd1);
    chk("seq_valid", 32'(ifid_valid), 32'd1);
    chk("seq_instr0", ifid_instr, mem[0]);
    run(2);
    chk("seq_pc3", 32'(im_readAddr), 32'd3);
    chk("seq_count3", 32'(fetch_count), 32'd3);

    // Jump to 43 from pc=40
    cyc(0, 0, 0, 0, 16'h0, 1, 26'd40);
    chk("jmp_pc40", 32'(im_readAddr), 32'd40);
    cyc(0, 0, 0, 0, 16'h0, 1, 26'd43);
    chk("jmp_pc43", 32'(im_readAddr), 32'd43);
    chk("jmp_bubble_v", 32'(ifid_valid), 32'd0);
    chk("jmp_bubble_i", ifid_instr, 32'd0);
    run(1);
    chk("jmp_instr43", ifid_instr, mem[43]);
    chk("jmp_pc1_44", 32'(ifid_pc_plus1), 32'd44);

    // Branch relative to ifid_pc_plus1=36, forward then backward
    cyc(0, 0, 0, 0, 16'h0, 1, 26'd35);
    run(1);
    chk("br_pc1_36", 32'(ifid_pc_plus1), 32'd36);
    cyc(0, 0, 0, 1, 16'd4, 0, 26'h0);
    chk("br_fwd_pc", 32'(im_readAddr), 32'd40);
    chk("br_fwd_bubble", 32'(ifid_valid), 32'd0);
    cyc(0, 0, 0, 1, 16'hFFFC, 0, 26'h0);
    chk("br_back_pc", 32'(im_readAddr), 32'd32);
    // Jump beats branch
    cyc(0, 0, 0, 1, 16'd4, 1, 26'd77);
    chk("jmp_over_br", 32'(im_readAddr), 32'd77);

    // Stall at pc=10, then stall with jump
    cyc(0, 0, 0, 0, 16'h0, 1, 26'd9);
    run(1);
    saved_cnt = fetch_count;
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 16'h0, 0, 26'h0);
    chk("stall_pc", 32'(im_readAddr), 32'd10);
    chk("stall_instr", ifid_instr, mem[9]);
    chk("stall_count", 32'(fetch_count), 32'(saved_cnt));
    cyc(0, 1, 0, 0, 16'h0, 1, 26'd20);
    chk("stall_jmp_pc", 32'(im_readAddr), 32'd20);

    // Flush with stall: bubble and pc holds
    run(1);
    cyc(0, 1, 1, 0, 16'h0, 0, 26'h0);
    chk("flush_stall_pc", 32'(im_readAddr), 32'd21);
    chk("flush_stall_v", 32'(ifid_valid), 32'd0);

    // Wrap from 127 to 0
    cyc(0, 0, 0, 0, 16'h0, 1, 26'h3FF_FFFF);
    chk("wrap_pc127", 32'(im_readAddr), 32'd127);
    run(1);
    chk("wrap_pc0", 32'(im_readAddr), 32'd0);
    chk("wrap_pc1", 32'(ifid_pc_plus1), 32'd0);
    chk("wrap_instr", ifid_instr, mem[127]);

    // Saturation of the fetch counter
    run(CMAX + 4);
    chk("sat_count", 32'(fetch_count), 32'(CMAX));

    // Reset overrides jump, flush and stall
    cyc(1, 1, 1, 1, 16'd5, 1, 26'd50);
    chk("rst_all_pc", 32'(im_readAddr), 32'd0);
    chk("rst_all_instr", ifid_instr, 32'd0);
    chk("rst_all_count", 32'(fetch_count), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(63) == 0, $urandom_range(3) == 0, $urandom_range(7) == 0,
          $urandom_range(7) == 0, 16'($urandom), $urandom_range(9) == 0, 26'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
